// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control encodings, funct3 codes and sequencer states.
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLTU = 4'b0101,
    ALU_NONE = 4'b1111
  } alu_ctrl_e;
  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} seq_state_e;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: maps funct3/sub to the ALU control code and flags illegal combinations.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       sub,
  output alu_ctrl_e  ctrl,
  output logic       illegal
);
  always_comb begin
    illegal = (sub && funct3 != FUNCT3_ADD) ||
              !(funct3 inside {FUNCT3_ADD, FUNCT3_XOR, FUNCT3_OR, FUNCT3_AND, FUNCT3_SLTU});
    ctrl = illegal                ? ALU_NONE :
           funct3 == FUNCT3_ADD   ? (sub ? ALU_SUB : ALU_ADD) :
           funct3 == FUNCT3_XOR   ? ALU_XOR :
           funct3 == FUNCT3_OR    ? ALU_OR :
           funct3 == FUNCT3_AND   ? ALU_AND : ALU_SLTU;
  end
endmodule

// File: rtl/alu_req_seq.sv
// alu_req_seq: valid/ready request sequencer driving a combinational ALU and returning its result.
// ALU_RSP_SKID_EN replaces the RESP state with a 2-entry response FIFO.
module alu_req_seq
  import alu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic             req_sub,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [3:0]       alu_ctrl_o,
  output logic [31:0]      alu_a_o,
  output logic [31:0]      alu_b_o,
  input  logic [31:0]      alu_result_i,
  input  logic             alu_zero_i,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [CNT_W-1:0] op_cnt
);
  alu_ctrl_e        dec_ctrl, ctrl_q, ctrl_d;
  logic             dec_ill;
  seq_state_e       state_q, state_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic             err_q, err_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_fire, rsp_fire, exec;
  logic [31:0]      cap_result;
  logic             cap_zero;
  alu_op_decode u_dec (
    .funct3  (req_funct3),
    .sub     (req_sub),
    .ctrl    (dec_ctrl),
    .illegal (dec_ill)
  );
  assign exec       = state_q == EXEC;
  assign req_fire   = req_valid & req_ready;
  assign rsp_fire   = rsp_valid & rsp_ready;
  // An illegal op still occupies a slot but reports a fixed 0/zero result
  assign cap_result = err_q ? '0 : alu_result_i;
  assign cap_zero   = err_q | alu_zero_i;
  assign alu_ctrl_o = ctrl_q;
  assign alu_a_o    = a_q;
  assign alu_b_o    = b_q;
  assign op_cnt     = cnt_q;
  always_comb begin
    ctrl_d = req_fire ? dec_ctrl : ctrl_q;
    a_d    = req_fire ? req_a : a_q;
    b_d    = req_fire ? req_b : b_q;
    err_d  = req_fire ? dec_ill : err_q;
    tag_d  = req_fire ? req_tag : tag_q;
    cnt_d  = cnt_q + CNT_W'(rsp_fire);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ctrl_q  <= ALU_NONE;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
      tag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef ALU_RSP_SKID_EN
  logic [31:0]      res_q [2];
  logic [31:0]      res_d [2];
  logic [TAG_W-1:0] rtag_q [2];
  logic [TAG_W-1:0] rtag_d [2];
  logic [1:0]       zero_q, zero_d, rerr_q, rerr_d, fill_q, fill_d;
  logic             wp_q, wp_d, rp_q, rp_d;
  assign req_ready  = state_q == IDLE && fill_q < 2'd2;
  assign rsp_valid  = fill_q != 2'd0;
  assign rsp_result = res_q[rp_q];
  assign rsp_zero   = zero_q[rp_q];
  assign rsp_err    = rerr_q[rp_q];
  assign rsp_tag    = rtag_q[rp_q];
  always_comb begin
    state_d = state_q == IDLE && req_fire ? EXEC : IDLE;
    res_d   = res_q;
    rtag_d  = rtag_q;
    zero_d  = zero_q;
    rerr_d  = rerr_q;
    if (exec) begin
      res_d[wp_q]  = cap_result;
      zero_d[wp_q] = cap_zero;
      rerr_d[wp_q] = err_q;
      rtag_d[wp_q] = tag_q;
    end
    wp_d   = wp_q ^ exec;
    rp_d   = rp_q ^ rsp_fire;
    fill_d = fill_q + {1'b0, exec} - {1'b0, rsp_fire};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q  <= '{default: '0};
      rtag_q <= '{default: '0};
      zero_q <= '0;
      rerr_q <= '0;
      wp_q   <= 1'b0;
      rp_q   <= 1'b0;
      fill_q <= '0;
    end else begin
      res_q  <= res_d;
      rtag_q <= rtag_d;
      zero_q <= zero_d;
      rerr_q <= rerr_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      fill_q <= fill_d;
    end
  end
`else
  logic [31:0]      res_q, res_d;
  logic [TAG_W-1:0] rtag_q, rtag_d;
  logic             zero_q, zero_d, rerr_q, rerr_d;
  assign req_ready  = state_q == IDLE;
  assign rsp_valid  = state_q == RESP;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = rerr_q;
  assign rsp_tag    = rtag_q;
  always_comb begin
    state_d = state_q == IDLE ? (req_fire ? EXEC : IDLE) :
              state_q == EXEC ? RESP : (rsp_fire ? IDLE : RESP);
    res_d   = exec ? cap_result : res_q;
    zero_d  = exec ? cap_zero : zero_q;
    rerr_d  = exec ? err_q : rerr_q;
    rtag_d  = exec ? tag_q : rtag_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q  <= '0;
      rtag_q <= '0;
      zero_q <= 1'b0;
      rerr_q <= 1'b0;
    end else begin
      res_q  <= res_d;
      rtag_q <= rtag_d;
      zero_q <= zero_d;
      rerr_q <= rerr_d;
    end
  end
`endif
endmodule

// File: tb/tb_alu_req_seq.sv
// tb_alu_req_seq: scoreboard bench for alu_req_seq with a behavioural ALU stub and reference model.
module tb_alu_req_seq;
  localparam int TAG_W = 4;
  localparam int CNT_W = 16;
`ifdef ALU_RSP_SKID_EN
  localparam int SPACING = 2;
  localparam bit SKID = 1'b1;
`else
  localparam int SPACING = 3;
  localparam bit SKID = 1'b0;
`endif
  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        e;
    logic [3:0]  t;
  } rsp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid, req_ready, req_sub, rsp_valid, rsp_ready = 1'b1;
  logic [2:0] req_funct3;
  logic [31:0] req_a, req_b, alu_a_o, alu_b_o, alu_res, rsp_result;
  logic [TAG_W-1:0] req_tag, rsp_tag;
  logic [3:0] alu_ctrl_o;
  logic alu_zero, rsp_zero, rsp_err;
  logic [CNT_W-1:0] op_cnt;
  logic [CNT_W-1:0] exp_cnt = '0;
  rsp_t exp_q[$];
  rsp_t mon_e;
  int hs_q[$];
  int vec = 0, bad = 0, cyc = 0, rr_mode = 0;
  alu_req_seq #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3), .req_sub(req_sub),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_ctrl_o(alu_ctrl_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_result_i(alu_res), .alu_zero_i(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err), .rsp_tag(rsp_tag), .op_cnt(op_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // ALU core stand-in; the non-code output is deliberately nonzero so error masking is visible
  always_comb begin
    case (alu_ctrl_o)
      4'h0:    alu_res = alu_a_o + alu_b_o;
      4'h1:    alu_res = alu_a_o - alu_b_o;
      4'h2:    alu_res = alu_a_o & alu_b_o;
      4'h3:    alu_res = alu_a_o | alu_b_o;
      4'h4:    alu_res = alu_a_o ^ alu_b_o;
      4'h5:    alu_res = {31'b0, alu_a_o < alu_b_o};
      default: alu_res = 32'hDEAD_BEEF;
    endcase
    alu_zero = alu_res == 32'd0;
  end
  always @(posedge clk) begin
    #2;
    rsp_ready = rr_mode == 0 ? 1'b1 : rr_mode == 1 ? 1'b0 : ($urandom_range(0, 3) != 0);
  end
  function automatic rsp_t model(input logic [2:0] f3, input logic s, input logic [31:0] a, b, input logic [3:0] t);
    logic [31:0] r;
    logic e;
    e = s && f3 != 3'b000;
    case (f3)
      3'b000:  r = s ? a - b : a + b;
      3'b100:  r = a ^ b;
      3'b110:  r = a | b;
      3'b111:  r = a & b;
      3'b011:  r = a < b ? 32'd1 : 32'd0;
      default: begin r = '0; e = 1'b1; end
    endcase
    if (e) r = '0;
    return {r, r == 32'd0, e, t};
  endfunction
  function automatic logic [3:0] ctrl_of(input logic [2:0] f3, input logic s);
    if (s && f3 != 3'b000) return 4'hF;
    case (f3)
      3'b000:  return s ? 4'h1 : 4'h0;
      3'b111:  return 4'h2;
      3'b110:  return 4'h3;
      3'b100:  return 4'h4;
      3'b011:  return 4'h5;
      default: return 4'hF;
    endcase
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic send(input logic [2:0] f3, input logic s, input logic [31:0] a, b, input logic [3:0] t, input bit track);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = f3; req_sub = s; req_a = a; req_b = b; req_tag = t;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    if (track) exp_q.push_back(model(f3, s, a, b, t));
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask
  always @(negedge clk or posedge rst) begin
    if (rst) exp_cnt = '0;
    else if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_without_req", rsp_valid, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("rsp_payload", {rsp_result, rsp_zero, rsp_err, rsp_tag}, mon_e);
      end
      chk("op_cnt", op_cnt, exp_cnt);
      exp_cnt++;
      hs_q.push_back(cyc);
    end
  end
  logic [2:0]  d_f3 [10] = '{3'b000, 3'b000, 3'b011, 3'b011, 3'b010, 3'b100, 3'b100, 3'b110, 3'b111, 3'b101};
  logic        d_s  [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] d_a  [10] = '{32'd9, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd3, 32'd3, 32'hF0F0_0000, 32'h0000_00F0, 32'hFF00_FF00, 32'd4};
  logic [31:0] d_b  [10] = '{32'd9, 32'd1, 32'hFFFF_FFFF, 32'd1, 32'd4, 32'd4, 32'hFFFF_0000, 32'h0000_0F00, 32'h0F0F_0F0F, 32'd4};
  initial begin
    int n;
    req_valid = 1'b0; req_funct3 = '0; req_sub = 1'b0; req_a = '0; req_b = '0; req_tag = '0;
    repeat (2) @(negedge clk);
    chk("rst_alu_ctrl", alu_ctrl_o, 4'hF);
    chk("rst_alu_ab", {alu_a_o, alu_b_o}, 0);
    chk("rst_rsp", {rsp_valid, rsp_result, rsp_zero, rsp_err, rsp_tag}, 0);
    chk("rst_op_cnt", op_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_rst", req_ready, 1);
    send(3'b000, 1'b0, 32'd5, 32'd7, 4'd3, 1'b1);
    chk("ctrl_add", alu_ctrl_o, 4'h0);
    @(negedge clk);
    chk("latency_exec", rsp_valid, 0);
    @(negedge clk);
    chk("latency_resp", rsp_valid, 1);
    drain();
    for (int i = 0; i < 10; i++) begin
      send(d_f3[i], d_s[i], d_a[i], d_b[i], 4'(i + 4), 1'b1);
      chk("ctrl_directed", alu_ctrl_o, ctrl_of(d_f3[i], d_s[i]));
      drain();
    end
    rr_mode = 1;
    send(3'b110, 1'b0, 32'hF0, 32'h0F, 4'hA, 1'b1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      @(negedge clk);
      chk("stall_payload", {rsp_valid, rsp_result, rsp_zero, rsp_err, rsp_tag}, {1'b1, 32'hFF, 1'b0, 1'b0, 4'hA});
      chk("stall_req_ready", req_ready, SKID);
    end
    n = exp_cnt;
    rr_mode = 0;
    drain();
    repeat (2) @(negedge clk);
    chk("stall_op_cnt", op_cnt, 64'(n + 1));
    hs_q.delete();
    for (int i = 1; i <= 4; i++) send(3'b000, 1'b0, $urandom, $urandom, 4'(i), 1'b1);
    drain();
    chk("b2b_count", hs_q.size(), 4);
    for (int i = 1; i < hs_q.size(); i++) chk("b2b_spacing", hs_q[i] - hs_q[i-1], SPACING);
    rr_mode = 1;
    send(3'b000, 1'b0, 32'd1, 32'd2, 4'd5, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_op_cnt", op_cnt, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_alu_ctrl", alu_ctrl_o, 4'hF);
    @(negedge clk);
    rst = 1'b0;
    rr_mode = 0;
    @(negedge clk);
    chk("midrst_req_ready", req_ready, 1);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_rsp", rsp_valid, 0);
    end
    send(3'b111, 1'b0, 32'hFFFF_0000, 32'h00FF_FF00, 4'd9, 1'b1);
    drain();
    rr_mode = 2;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, b;
      a = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom;
      b = $urandom_range(0, 3) == 0 ? a : $urandom;
      send(3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0, a, b, 4'($urandom), 1'b1);
    end
    rr_mode = 0;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vec, bad);
    $fatal(1);
  end
endmodule
